// File: rtl/gpio_port_bank_if.sv
// Register-access bus for gpio_port_bank: one write port (bit/word/mask modes) and one
// registered read port. The master drives requests; the slave returns rd_data.
interface gpio_port_bank_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
);
    logic             wr_en;
    logic [1:0]       wr_target;
    logic [1:0]       wr_mode;
    logic [IDX_W-1:0] bit_idx;
    logic             bit_val;
    logic [WIDTH-1:0] wr_data;
    logic [1:0]       rd_target;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output wr_en, wr_target, wr_mode, bit_idx, bit_val, wr_data, rd_target,
        input  rd_data
    );

    modport slave (
        input  wr_en, wr_target, wr_mode, bit_idx, bit_val, wr_data, rd_target,
        output rd_data
    );
endinterface

// File: rtl/gpio_port_bank.sv
// GPIO bank: out/dir registers, synchronised pin inputs, registered reads. Edge interrupts
// (irq_en, irq_status, arm counter) are built only when GPIO_IRQ_EN is defined.
module gpio_port_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    gpio_port_bank_if.slave  bus,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    output logic             irq
);
    localparam logic [1:0] T_OUT = 2'd0;
    localparam logic [1:0] T_DIR = 2'd1;
    localparam logic [1:0] T_EN  = 2'd2;
    localparam logic [1:0] T_ST  = 2'd3;
    localparam logic [1:0] M_BIT  = 2'd0;
    localparam logic [1:0] M_WORD = 2'd1;
    localparam logic [1:0] M_SET  = 2'd2;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] synced;
    logic [WIDTH-1:0] onehot;
    logic [WIDTH-1:0] st_rd;

    assign synced = sync_q[SYNC_STAGES-1];
    // Shifting past WIDTH yields zero, so out-of-range bit writes become no-ops.
    assign onehot = {{(WIDTH-1){1'b0}}, 1'b1} << bus.bit_idx;

    function automatic logic [WIDTH-1:0] apply_write(
        input logic [WIDTH-1:0] cur,
        input logic [1:0]       mode,
        input logic             val,
        input logic [WIDTH-1:0] mask,
        input logic [WIDTH-1:0] data
    );
        case (mode)
            M_BIT:   return val ? (cur | mask) : (cur & ~mask);
            M_WORD:  return data;
            M_SET:   return cur | data;
            default: return cur & ~data;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

`ifdef GPIO_IRQ_EN
    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(ARM_MAX + 1);

    logic [ARM_W-1:0] arm_q, arm_d;
    logic             armed;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] en_q, en_d;
    logic [WIDTH-1:0] st_q, st_d;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] clr_mask;

    // The sync chain leaves reset at 0, so the first SYNC_STAGES+1 cycles may show false edges.
    assign armed    = (arm_q == ARM_W'(ARM_MAX));
    assign edge_set = (synced ^ prev_q) & en_q & {WIDTH{armed}};

    always_comb begin
        arm_d    = armed ? arm_q : arm_q + 1'b1;
        en_d     = en_q;
        clr_mask = '0;
        if (bus.wr_en && bus.wr_target == T_EN)
            en_d = apply_write(en_q, bus.wr_mode, bus.bit_val, onehot, bus.wr_data);
        if (bus.wr_en && bus.wr_target == T_ST)
            clr_mask = (bus.wr_mode == M_BIT) ? (bus.bit_val ? onehot : '0) : bus.wr_data;
        st_d = (st_q & ~clr_mask) | edge_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arm_q  <= '0;
            prev_q <= '0;
            en_q   <= '0;
            st_q   <= '0;
        end else begin
            arm_q  <= arm_d;
            prev_q <= synced;
            en_q   <= en_d;
            st_q   <= st_d;
        end
    end

    assign st_rd = st_q;
    assign irq   = |st_q;
`else
    assign st_rd = '0;
    assign irq   = 1'b0;
`endif

    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        if (bus.wr_en && bus.wr_target == T_OUT)
            out_d = apply_write(out_q, bus.wr_mode, bus.bit_val, onehot, bus.wr_data);
        if (bus.wr_en && bus.wr_target == T_DIR)
            dir_d = apply_write(dir_q, bus.wr_mode, bus.bit_val, onehot, bus.wr_data);
        case (bus.rd_target)
            T_OUT:   rd_d = out_q;
            T_DIR:   rd_d = dir_q;
            T_EN:    rd_d = synced;
            default: rd_d = st_rd;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
            dir_q <= '0;
            rd_q  <= '0;
        end else begin
            out_q <= out_d;
            dir_q <= dir_d;
            rd_q  <= rd_d;
        end
    end

    assign bus.rd_data = rd_q;
    assign pin_out     = out_q;
    assign pin_oe      = dir_q;
endmodule

// File: tb/tb_gpio_port_bank.sv
// Bench for gpio_port_bank: an 8-pin bank against a behavioural model with random traffic,
// plus a 6-pin bank for out-of-range bit writes. Interrupt checks follow GPIO_IRQ_EN.
module tb_gpio_port_bank;
    localparam int S  = 2;
    localparam int S6 = 3;
`ifdef GPIO_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pin8, pout8, poe8;
    logic [5:0] pin6, pout6, poe6;
    logic       irq8, irq6;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    gpio_port_bank_if #(.WIDTH(8)) b8 ();
    gpio_port_bank_if #(.WIDTH(6)) b6 ();

    gpio_port_bank #(.WIDTH(8), .SYNC_STAGES(S)) u_dut8 (
        .clk(clk), .rst(rst), .bus(b8), .pin_in(pin8),
        .pin_out(pout8), .pin_oe(poe8), .irq(irq8)
    );
    gpio_port_bank #(.WIDTH(6), .SYNC_STAGES(S6)) u_dut6 (
        .clk(clk), .rst(rst), .bus(b6), .pin_in(pin6),
        .pin_out(pout6), .pin_oe(poe6), .irq(irq6)
    );

    // Behavioural model of the 8-pin bank.
    logic [7:0] m_out, m_dir, m_en, m_st, m_rd;
    logic [7:0] pq[$];
    int         m_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] upd(input logic [7:0] cur, input logic [1:0] mode,
                                       input logic [2:0] idx, input logic v, input logic [7:0] d);
        logic [7:0] r;
        r = cur;
        case (mode)
            2'd0: r[idx] = v;
            2'd1: r = d;
            2'd2: r = cur | d;
            default: r = cur & ~d;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_out = 0; m_dir = 0; m_en = 0; m_st = 0; m_rd = 0; m_cyc = 0;
        pq.delete();
        for (int i = 0; i <= S; i++) pq.push_back(8'h00);
    endtask

    task automatic model_edge();
        logic [7:0] syn, prv, clr, setv, n_out, n_dir, n_en;
        syn = pq[S-1];
        prv = pq[S];
        case (b8.rd_target)
            2'd0: m_rd = m_out;
            2'd1: m_rd = m_dir;
            2'd2: m_rd = syn;
            default: m_rd = m_st;
        endcase
        n_out = m_out; n_dir = m_dir; n_en = m_en; clr = 8'h00;
        if (b8.wr_en) begin
            case (b8.wr_target)
                2'd0: n_out = upd(m_out, b8.wr_mode, b8.bit_idx, b8.bit_val, b8.wr_data);
                2'd1: n_dir = upd(m_dir, b8.wr_mode, b8.bit_idx, b8.bit_val, b8.wr_data);
                2'd2: if (IRQ) n_en = upd(m_en, b8.wr_mode, b8.bit_idx, b8.bit_val, b8.wr_data);
                default: clr = (b8.wr_mode == 2'd0) ? (b8.bit_val ? (8'h01 << b8.bit_idx) : 8'h00)
                                                    : b8.wr_data;
            endcase
        end
        setv  = (IRQ && m_cyc >= S + 1) ? ((syn ^ prv) & m_en) : 8'h00;
        m_st  = IRQ ? ((m_st & ~clr) | setv) : 8'h00;
        m_out = n_out; m_dir = n_dir; m_en = n_en;
        pq.push_front(pin8);
        void'(pq.pop_back());
        m_cyc++;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("rd_data", b8.rd_data, m_rd);
        check("pin_out", pout8, m_out);
        check("pin_oe", poe8, m_dir);
        check("irq", irq8, |m_st);
    endtask

    task automatic wr8(input logic [1:0] tgt, input logic [1:0] mode, input logic [2:0] idx,
                       input logic v, input logic [7:0] d);
        b8.wr_en = 1'b1; b8.wr_target = tgt; b8.wr_mode = mode;
        b8.bit_idx = idx; b8.bit_val = v; b8.wr_data = d;
    endtask

    initial begin
        rst = 1'b0; pin8 = 8'hFF; pin6 = 6'h00;
        b8.wr_en = 0; b8.wr_target = 0; b8.wr_mode = 0; b8.bit_idx = 0; b8.bit_val = 0;
        b8.wr_data = 0; b8.rd_target = 0;
        b6.wr_en = 0; b6.wr_target = 0; b6.wr_mode = 0; b6.bit_idx = 0; b6.bit_val = 0;
        b6.wr_data = 0; b6.rd_target = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd", b8.rd_data, 0);
        check("rst_pin_oe", poe8, 0);
        check("rst_pin_out", pout8, 0);
        check("rst_irq", irq8, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Read all targets after release; pins held high must not raise status while arming.
        b8.rd_target = 2'd2; tick(); check("rd_sync_rst", b8.rd_data, 0);
        b8.rd_target = 2'd0; tick(); check("rd_out_rst", b8.rd_data, 0);
        b8.rd_target = 2'd1; tick(); check("rd_dir_rst", b8.rd_data, 0);
        b8.rd_target = 2'd3;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rd_st_arming", b8.rd_data, 0);
            check("irq_arming", irq8, 0);
        end

        // Word, set-mask, clear-mask, bit write on out.
        b8.rd_target = 2'd0;
        wr8(2'd0, 2'd1, 3'd0, 1'b0, 8'hA5); tick(); check("out_word", pout8, 8'hA5);
        wr8(2'd0, 2'd2, 3'd0, 1'b0, 8'h0F); tick(); check("out_set", pout8, 8'hAF);
        wr8(2'd0, 2'd3, 3'd0, 1'b0, 8'h81); tick(); check("out_clr", pout8, 8'h2E);
        check("rd_pre_write", b8.rd_data, 8'hAF);
        wr8(2'd0, 2'd0, 3'd3, 1'b0, 8'h00); tick(); check("out_bit", pout8, 8'h26);
        b8.wr_en = 1'b0;

        // 6-pin bank: out-of-range bit index and read latency.
        b6.wr_en = 1'b1; b6.wr_target = 2'd0; b6.wr_mode = 2'd1; b6.wr_data = 6'h15;
        tick(); check("w6_word", pout6, 6'h15); check("w6_rd_old0", b6.rd_data, 0);
        b6.wr_mode = 2'd0; b6.bit_idx = 3'd7; b6.bit_val = 1'b1;
        tick(); check("w6_oob_out", pout6, 6'h15); check("w6_rd", b6.rd_data, 6'h15);
        b6.wr_target = 2'd1;
        tick(); check("w6_oob_dir", poe6, 6'h00);
        b6.wr_target = 2'd0; b6.bit_idx = 3'd1;
        tick(); check("w6_bit_pin", pout6, 6'h17); check("w6_rd_same_cycle", b6.rd_data, 6'h15);
        b6.wr_en = 1'b0;
        tick(); check("w6_rd_next", b6.rd_data, 6'h17);

`ifdef GPIO_IRQ_EN
        wr8(2'd2, 2'd1, 3'd0, 1'b0, 8'h01); tick();
        b8.wr_en = 1'b0; b8.rd_target = 2'd3;
        tick(); check("st_before_toggle", b8.rd_data, 0);
        pin8 = 8'hFE;
        for (int k = 0; k < S; k++) begin
            tick(); check("irq_latency_early", irq8, 0);
        end
        tick(); check("irq_latency", irq8, 1);
        tick(); check("st_read_bit0", b8.rd_data, 8'h01);

        wr8(2'd2, 2'd1, 3'd0, 1'b0, 8'h03); tick();
        b8.wr_en = 1'b0; pin8 = 8'hFC;
        for (int k = 0; k < S + 1; k++) tick();
        tick(); check("st_both", b8.rd_data, 8'h03);
        pin8 = 8'hFD;
        for (int k = 0; k < S; k++) tick();
        wr8(2'd3, 2'd1, 3'd0, 1'b0, 8'h03); tick();
        b8.wr_en = 1'b0;
        tick(); check("w1c_race", b8.rd_data, 8'h01);
        wr8(2'd3, 2'd0, 3'd0, 1'b1, 8'h00); tick();
        b8.wr_en = 1'b0;
        tick(); check("w1c_bit", b8.rd_data, 8'h00); check("irq_cleared", irq8, 0);
`else
        wr8(2'd2, 2'd1, 3'd0, 1'b0, 8'hFF); tick();
        b8.wr_en = 1'b0; b8.rd_target = 2'd3;
        for (int k = 0; k < 6; k++) begin
            pin8 = pin8 ^ 8'h55;
            tick(); check("noirq_irq", irq8, 0); check("noirq_st", b8.rd_data, 0);
        end
`endif

        for (int k = 0; k < 400; k++) begin
            b8.wr_en     = 1'($urandom_range(0, 1));
            b8.wr_target = 2'($urandom_range(0, 3));
            b8.wr_mode   = 2'($urandom_range(0, 3));
            b8.bit_idx   = 3'($urandom_range(0, 7));
            b8.bit_val   = 1'($urandom_range(0, 1));
            b8.wr_data   = 8'($urandom);
            b8.rd_target = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) pin8 = 8'($urandom);
            tick();
        end

        // Asynchronous reset in the middle of a pending write.
        wr8(2'd1, 2'd1, 3'd0, 1'b0, 8'hFF); tick();
        wr8(2'd0, 2'd1, 3'd0, 1'b0, 8'hC3); tick();
        check("pre_rst_out", pout8, 8'hC3); check("pre_rst_oe", poe8, 8'hFF);
        wr8(2'd0, 2'd1, 3'd0, 1'b0, 8'h5A);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check("async_rst_out", pout8, 0);
        check("async_rst_oe", poe8, 0);
        check("async_rst_rd", b8.rd_data, 0);
        check("async_rst_irq", irq8, 0);
        @(posedge clk);
        #1;
        check("rst_hold_out", pout8, 0);
        b8.wr_en = 1'b0; b8.rd_target = 2'd0;
        rst = 1'b1;
        tick(); check("post_rst_out", pout8, 0);
        for (int k = 0; k < 20; k++) begin
            b8.wr_en     = 1'($urandom_range(0, 1));
            b8.wr_target = 2'($urandom_range(0, 3));
            b8.wr_mode   = 2'($urandom_range(0, 3));
            b8.wr_data   = 8'($urandom);
            b8.rd_target = 2'($urandom_range(0, 3));
            pin8 = 8'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
